// File: rtl/rl_fifo_1r1w_ctrl.sv
// First-word-fall-through FIFO controller for an external 1R1W RAM with registered read.
// Optional synchronous flush_i port when RL_FIFO_FLUSH_EN is defined.
module rl_fifo_1r1w_ctrl #(
  parameter int unsigned ABITS    = 10,
  parameter int unsigned DBITS    = 32,
  parameter int unsigned AF_LEVEL = 2**ABITS - 4
) (
  input  logic                   rst_ni,
  input  logic                   clk_i,
`ifdef RL_FIFO_FLUSH_EN
  input  logic                   flush_i,
`endif
  input  logic                   push_i,
  input  logic [DBITS-1:0]       din_i,
  input  logic                   pop_i,
  output logic [DBITS-1:0]       dout_o,
  output logic                   empty_o,
  output logic                   full_o,
  output logic                   almost_full_o,
  output logic [ABITS:0]         usedw_o,
  output logic                   ovf_o,
  output logic                   udf_o,
  output logic [ABITS-1:0]       ram_waddr_o,
  output logic [DBITS-1:0]       ram_din_o,
  output logic                   ram_we_o,
  output logic [(DBITS+7)/8-1:0] ram_be_o,
  output logic [ABITS-1:0]       ram_raddr_o,
  input  logic [DBITS-1:0]       ram_dout_i
);

  localparam logic [ABITS:0] DEPTH  = {1'b1, {ABITS{1'b0}}};
  localparam logic [ABITS:0] AF_LVL = (ABITS+1)'(AF_LEVEL);

  logic [ABITS:0] wr_ptr_q, wr_ptr_d;
  logic [ABITS:0] rd_ptr_q, rd_ptr_d;
  logic [ABITS:0] wr_vis_q, wr_vis_d;
  logic           full_q, full_d;
  logic           af_q, af_d;
  logic           ovf_q, ovf_d;
  logic           udf_q, udf_d;

  logic           flush;
  logic           empty;
  logic           push_acc;
  logic           pop_acc;
  logic [ABITS:0] usedw_d;

`ifdef RL_FIFO_FLUSH_EN
  assign flush = flush_i;
`else
  assign flush = 1'b0;
`endif

  always_comb begin
    empty    = (rd_ptr_q == wr_vis_q);
    push_acc = push_i & ~full_q & ~flush;
    pop_acc  = pop_i & ~empty & ~flush;

    wr_ptr_d = wr_ptr_q + {{ABITS{1'b0}}, push_acc};
    rd_ptr_d = rd_ptr_q + {{ABITS{1'b0}}, pop_acc};
    // Visibility lags the write by one cycle so the RAM's old-data read-during-write never reaches dout_o.
    wr_vis_d = wr_ptr_q;
    ovf_d    = ovf_q | (push_i & full_q);
    udf_d    = udf_q | (pop_i & empty);

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      wr_vis_d = '0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end

    usedw_d = wr_ptr_d - rd_ptr_d;
    full_d  = (usedw_d == DEPTH);
    af_d    = (usedw_d >= AF_LVL);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      wr_vis_q <= '0;
      full_q   <= 1'b0;
      af_q     <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      wr_vis_q <= wr_vis_d;
      full_q   <= full_d;
      af_q     <= af_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  assign dout_o        = ram_dout_i;
  assign empty_o       = empty;
  assign full_o        = full_q;
  assign almost_full_o = af_q;
  assign usedw_o       = wr_ptr_q - rd_ptr_q;
  assign ovf_o         = ovf_q;
  assign udf_o         = udf_q;

  assign ram_waddr_o = wr_ptr_q[ABITS-1:0];
  assign ram_din_o   = din_i;
  assign ram_we_o    = push_acc & rst_ni;
  assign ram_be_o    = '1;
  // Read address runs one step ahead so the RAM output tracks the updated head pointer.
  assign ram_raddr_o = rd_ptr_d[ABITS-1:0];

endmodule

// File: tb/tb_rl_fifo_1r1w_ctrl.sv
// Self-checking bench for rl_fifo_1r1w_ctrl (ABITS=4, DBITS=8) with a behavioural RAM
// and a queue-based reference model; flush test only when RL_FIFO_FLUSH_EN is defined.
module tb_rl_fifo_1r1w_ctrl;

  localparam int DEPTH = 16;

  logic       clk_i = 1'b0;
  logic       rst_ni;
`ifdef RL_FIFO_FLUSH_EN
  logic       flush_i;
`endif
  logic       push_i, pop_i;
  logic [7:0] din_i, dout_o;
  logic       empty_o, full_o, almost_full_o, ovf_o, udf_o;
  logic [4:0] usedw_o;
  logic [3:0] ram_waddr_o, ram_raddr_o;
  logic [7:0] ram_din_o, ram_dout_i;
  logic       ram_we_o;
  logic [0:0] ram_be_o;

  logic [7:0] mem [DEPTH];

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  q [$];
  bit          pend;
  bit          ovf_m, udf_m;
  int unsigned pops_total;
  bit          exp_we;
  int unsigned exp_raddr;
  logic        pre_we;
  logic [3:0]  pre_raddr;

  rl_fifo_1r1w_ctrl #(.ABITS(4), .DBITS(8)) dut (
    .rst_ni(rst_ni), .clk_i(clk_i),
`ifdef RL_FIFO_FLUSH_EN
    .flush_i(flush_i),
`endif
    .push_i(push_i), .din_i(din_i), .pop_i(pop_i), .dout_o(dout_o),
    .empty_o(empty_o), .full_o(full_o), .almost_full_o(almost_full_o),
    .usedw_o(usedw_o), .ovf_o(ovf_o), .udf_o(udf_o),
    .ram_waddr_o(ram_waddr_o), .ram_din_o(ram_din_o), .ram_we_o(ram_we_o),
    .ram_be_o(ram_be_o), .ram_raddr_o(ram_raddr_o), .ram_dout_i(ram_dout_i)
  );

  always #5 clk_i = ~clk_i;

  // External RAM: registered read, old data on read-during-write.
  always @(posedge clk_i) begin
    if (ram_we_o) mem[ram_waddr_o] <= ram_din_o;
    ram_dout_i <= mem[ram_raddr_o];
  end

  function automatic bit m_empty();
    return (q.size() - int'(pend)) == 0;
  endfunction

  task automatic model_clear();
    q.delete();
    pend = 0; ovf_m = 0; udf_m = 0; pops_total = 0;
  endtask

  // One clock: drive inputs, sample combinational RAM controls, advance the model.
  task automatic drive(input bit p, input bit r, input logic [7:0] d, input bit f);
    bit full_m, empty_m, ap, ar;
    push_i = p; pop_i = r; din_i = d;
`ifdef RL_FIFO_FLUSH_EN
    flush_i = f;
`endif
    #1;
    full_m  = (q.size() == DEPTH);
    empty_m = m_empty();
    ap = p && !full_m && !f;
    ar = r && !empty_m && !f;
    exp_we    = ap;
    exp_raddr = f ? 0 : (pops_total + int'(ar)) % DEPTH;
    pre_we    = ram_we_o;
    pre_raddr = ram_raddr_o;
    @(posedge clk_i);
    if (f) model_clear();
    else begin
      ovf_m = ovf_m | (p && full_m);
      udf_m = udf_m | (r && empty_m);
      if (ar) begin void'(q.pop_front()); pops_total++; end
      if (ap) q.push_back(d);
      pend = ap;
    end
    #1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; push_i = 1'b1; pop_i = 1'b1; din_i = 8'h3C;
`ifdef RL_FIFO_FLUSH_EN
    flush_i = 1'b0;
`endif
    #2;
    n_checks++;
    if ({empty_o, full_o, almost_full_o, ovf_o, udf_o, ram_we_o} !== 6'b100000) begin
      n_fail++;
      $display("FAIL reset_flags: got e/f/af/ovf/udf/we=%b exp 100000",
               {empty_o, full_o, almost_full_o, ovf_o, udf_o, ram_we_o});
    end
    n_checks++;
    if (usedw_o !== 5'd0) begin n_fail++; $display("FAIL reset_usedw: got %0d exp 0", usedw_o); end
    @(posedge clk_i); #1;
    push_i = 1'b0; pop_i = 1'b0;
    rst_ni = 1'b1;
    model_clear();
  endtask

  task automatic test_first_word();
    drive(1, 0, 8'hA5, 0);
    n_checks++;
    if (empty_o !== 1'b1) begin n_fail++; $display("FAIL fw_empty_c1: got %b exp 1", empty_o); end
    drive(0, 0, 8'h00, 0);
    n_checks++;
    if (empty_o !== 1'b0 || dout_o !== 8'hA5) begin
      n_fail++; $display("FAIL fw_data_c2: got empty=%b dout=%h exp empty=0 dout=a5", empty_o, dout_o);
    end
    drive(0, 1, 8'h00, 0);
    n_checks++;
    if (empty_o !== 1'b1 || usedw_o !== 5'd0) begin
      n_fail++; $display("FAIL fw_drain: got empty=%b usedw=%0d exp 1/0", empty_o, usedw_o);
    end
  endtask

  task automatic test_fill_ovf();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 0, 8'(i), 0);
      n_checks++;
      if (usedw_o !== 5'(q.size()) || almost_full_o !== (q.size() >= 12) || full_o !== (q.size() == DEPTH)) begin
        n_fail++;
        $display("FAIL fill_level %0d: got usedw=%0d af=%b full=%b exp usedw=%0d", i, usedw_o, almost_full_o, full_o, q.size());
      end
    end
    n_checks++;
    if (full_o !== 1'b1 || usedw_o !== 5'd16) begin
      n_fail++; $display("FAIL fill_full: got full=%b usedw=%0d exp 1/16", full_o, usedw_o);
    end
    drive(1, 0, 8'hFF, 0);
    n_checks++;
    if (pre_we !== 1'b0 || ovf_o !== 1'b1 || usedw_o !== 5'd16) begin
      n_fail++; $display("FAIL ovf_push: got we=%b ovf=%b usedw=%0d exp 0/1/16", pre_we, ovf_o, usedw_o);
    end
    for (int i = 0; i < DEPTH; i++) begin
      n_checks++;
      if (empty_o !== 1'b0 || dout_o !== 8'(i)) begin
        n_fail++; $display("FAIL drain_data %0d: got empty=%b dout=%h exp 0/%h", i, empty_o, dout_o, 8'(i));
      end
      drive(0, 1, 8'h00, 0);
    end
    n_checks++;
    if (empty_o !== 1'b1 || usedw_o !== 5'd0 || udf_o !== 1'b0 || ovf_o !== 1'b1) begin
      n_fail++; $display("FAIL drain_end: got empty=%b usedw=%0d udf=%b ovf=%b exp 1/0/0/1", empty_o, usedw_o, udf_o, ovf_o);
    end
  endtask

  task automatic test_one_entry_push_pop();
    drive(1, 0, 8'h11, 0);
    drive(0, 0, 8'h00, 0);
    n_checks++;
    if (empty_o !== 1'b0 || dout_o !== 8'h11) begin
      n_fail++; $display("FAIL pp_setup: got empty=%b dout=%h exp 0/11", empty_o, dout_o);
    end
    drive(1, 1, 8'h22, 0);
    n_checks++;
    if (empty_o !== 1'b1 || usedw_o !== 5'd1) begin
      n_fail++; $display("FAIL pp_gap: got empty=%b usedw=%0d exp 1/1", empty_o, usedw_o);
    end
    drive(0, 0, 8'h00, 0);
    n_checks++;
    if (empty_o !== 1'b0 || dout_o !== 8'h22) begin
      n_fail++; $display("FAIL pp_data: got empty=%b dout=%h exp 0/22", empty_o, dout_o);
    end
    drive(0, 1, 8'h00, 0);
  endtask

  task automatic test_back_to_back_wrap();
    int unsigned k;
    k = $urandom_range(2, 8);
    for (int i = 0; i < int'(k); i++) drive(1, 0, 8'($urandom), 0);
    drive(0, 0, 8'h00, 0);
    for (int i = 0; i < 3 * DEPTH + 4; i++) begin
      n_checks++;
      if (empty_o !== 1'b0 || dout_o !== q[0]) begin
        n_fail++; $display("FAIL wrap_data %0d: got empty=%b dout=%h exp 0/%h", i, empty_o, dout_o, q[0]);
      end
      drive(1, 1, 8'($urandom), 0);
      n_checks++;
      if (usedw_o !== 5'(k) || pre_raddr !== 4'(exp_raddr) || pre_we !== 1'b1) begin
        n_fail++; $display("FAIL wrap_ctrl %0d: got usedw=%0d raddr=%0d we=%b exp %0d/%0d/1", i, usedw_o, pre_raddr, pre_we, k, exp_raddr);
      end
    end
    n_checks++;
    if (ovf_o !== ovf_m || udf_o !== 1'b0) begin
      n_fail++; $display("FAIL wrap_flags: got ovf=%b udf=%b exp %b/0", ovf_o, udf_o, ovf_m);
    end
    while (q.size() != 0) drive(0, 1, 8'h00, 0);
  endtask

  task automatic test_udf_and_midreset();
    drive(0, 0, 8'h00, 0);
    drive(0, 1, 8'h00, 0);
    n_checks++;
    if (udf_o !== 1'b1 || usedw_o !== 5'd0 || pre_raddr !== 4'(exp_raddr)) begin
      n_fail++; $display("FAIL udf_set: got udf=%b usedw=%0d raddr=%0d exp 1/0/%0d", udf_o, usedw_o, pre_raddr, exp_raddr);
    end
    drive(1, 0, 8'h5A, 0);
    drive(1, 0, 8'h5B, 0);
    n_checks++;
    if (udf_o !== 1'b1 || usedw_o !== 5'd2) begin
      n_fail++; $display("FAIL udf_sticky: got udf=%b usedw=%0d exp 1/2", udf_o, usedw_o);
    end
    push_i = 1'b1; din_i = 8'h77;
    rst_ni = 1'b0;
    #1;
    n_checks++;
    if ({empty_o, full_o, almost_full_o, ovf_o, udf_o, ram_we_o} !== 6'b100000 || usedw_o !== 5'd0) begin
      n_fail++;
      $display("FAIL midreset: got e/f/af/ovf/udf/we=%b usedw=%0d exp 100000/0",
               {empty_o, full_o, almost_full_o, ovf_o, udf_o, ram_we_o}, usedw_o);
    end
    @(posedge clk_i); #1;
    push_i = 1'b0;
    rst_ni = 1'b1;
    model_clear();
    drive(0, 0, 8'h00, 0);
    n_checks++;
    if (empty_o !== 1'b1 || usedw_o !== 5'd0 || udf_o !== 1'b0) begin
      n_fail++; $display("FAIL post_reset: got empty=%b usedw=%0d udf=%b exp 1/0/0", empty_o, usedw_o, udf_o);
    end
  endtask

  task automatic test_random();
    bit p, r;
    for (int i = 0; i < 400; i++) begin
      p = $urandom_range(0, 99) < (((i / 100) % 2) != 0 ? 30 : 80);
      r = $urandom_range(0, 99) < (((i / 100) % 2) != 0 ? 80 : 35);
      drive(p, r, 8'($urandom), 0);
      n_checks++;
      if (pre_we !== exp_we || pre_raddr !== 4'(exp_raddr)) begin
        n_fail++; $display("FAIL rand_ram %0d: got we=%b raddr=%0d exp %b/%0d", i, pre_we, pre_raddr, exp_we, exp_raddr);
      end
      n_checks++;
      if (usedw_o !== 5'(q.size()) || full_o !== (q.size() == DEPTH) || almost_full_o !== (q.size() >= 12)) begin
        n_fail++; $display("FAIL rand_level %0d: got usedw=%0d full=%b af=%b exp usedw=%0d", i, usedw_o, full_o, almost_full_o, q.size());
      end
      n_checks++;
      if (empty_o !== m_empty() || ovf_o !== ovf_m || udf_o !== udf_m) begin
        n_fail++; $display("FAIL rand_flags %0d: got e/ovf/udf=%b%b%b exp %b%b%b", i, empty_o, ovf_o, udf_o, m_empty(), ovf_m, udf_m);
      end
      if (!m_empty()) begin
        n_checks++;
        if (dout_o !== q[0]) begin n_fail++; $display("FAIL rand_data %0d: got %h exp %h", i, dout_o, q[0]); end
      end
    end
  endtask

`ifdef RL_FIFO_FLUSH_EN
  task automatic test_flush();
    while (q.size() != 0) drive(0, 1, 8'h00, 0);
    for (int i = 0; i < 5; i++) drive(1, 0, 8'(8'h40 + i), 0);
    drive(0, 1, 8'h00, 0);
    drive(1, 0, 8'hEE, 1);
    n_checks++;
    if (pre_we !== 1'b0 || empty_o !== 1'b1 || usedw_o !== 5'd0 || ovf_o !== 1'b0 || udf_o !== 1'b0) begin
      n_fail++; $display("FAIL flush: got we=%b empty=%b usedw=%0d ovf=%b udf=%b exp 0/1/0/0/0", pre_we, empty_o, usedw_o, ovf_o, udf_o);
    end
    drive(1, 0, 8'h99, 0);
    drive(0, 0, 8'h00, 0);
    n_checks++;
    if (empty_o !== 1'b0 || dout_o !== 8'h99 || usedw_o !== 5'd1) begin
      n_fail++; $display("FAIL flush_after: got empty=%b dout=%h usedw=%0d exp 0/99/1", empty_o, dout_o, usedw_o);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_first_word();
    test_fill_ovf();
    test_one_entry_push_pop();
    test_back_to_back_wrap();
    test_udf_and_midreset();
    test_random();
`ifdef RL_FIFO_FLUSH_EN
    test_flush();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
